dmem_arbiter: RTL and testbench

Two-port round-robin arbiter sharing the single-port 64x32 data memory between the processor load/store port (port 0) and the DMA/loader port (port 1). It sits between both requesters and the data memory: it drives the memory write enable, address and write data, registers read data back to the granted requester, and sequences one access per granted cycle.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_arbiter_if.sv | 34 +++
 rtl/dmem_arb_rr.sv | 18 +
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  localparam int ADDR_W_DEF   = 6;
  localparam int DATA_W_DEF   = 32;
  localparam int LOCK_MAX_DEF = 8;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  function automatic logic [1:0] own_state(input logic port);
    logic [1:0] s;
    s = port ? OWN1 : OWN0;
    return s;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one requester port of the data-memory arbiter
// lock signal exists only when DMEM_ARB_LOCK_EN is defined
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = dmem_arb_pkg::DATA_W_DEF
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
`ifdef DMEM_ARB_LOCK_EN
  logic              lock;
`endif

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid
`ifdef DMEM_ARB_LOCK_EN
    , output lock
`endif
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid
`ifdef DMEM_ARB_LOCK_EN
    , input lock
`endif
  );

endinterface

// File: rtl/dmem_arb_rr.sv
// rtl/dmem_arb_rr.sv - two-way round-robin picker
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    // Under contention the port that was not served last wins.
    if (&req) winner = ~last;
    else      winner = req[P_DMA] ? P_DMA : P_CPU;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data memory between two ports
// Optional beat locking enabled by DMEM_ARB_LOCK_EN
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef DMEM_ARB_LOCK_EN
  , parameter int LOCK_MAX = LOCK_MAX_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_OWN0 = OWN0;
  localparam logic [1:0] S_OWN1 = OWN1;

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

  logic [1:0] req;
  logic       owner;
  logic       own_valid;
  logic       beat;
  logic       sel_we;
  logic       other_req;
  logic       rr_winner;
  logic       rr_valid;
  logic [1:0] rr_state;

`ifdef DMEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);
  localparam logic [CNT_W-1:0] LOCK_SAT  = CNT_W'(LOCK_MAX);

  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             sel_lock;
`endif

  assign req = {m1.req, m0.req};

  dmem_arb_rr u_rr (
    .req    (req),
    .last   (last_q),
    .winner (rr_winner),
    .valid  (rr_valid)
  );

  always_comb begin
    owner     = (state_q == S_OWN1);
    own_valid = (state_q == S_OWN0) || (state_q == S_OWN1);
    beat      = own_valid & req[owner];
    sel_we    = owner ? m1.we : m0.we;
    other_req = req[~owner];
    rr_state  = rr_valid ? own_state(rr_winner) : S_IDLE;
  end

  assign m0.gnt = beat & ~owner;
  assign m1.gnt = beat & owner;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (own_valid) begin
      mem_we    = beat & sel_we;
      mem_addr  = owner ? m1.addr  : m0.addr;
      mem_wdata = owner ? m1.wdata : m0.wdata;
    end
  end

  // Read data is captured at the granted edge and held until that port's next read.
  always_comb begin
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    if (m0.gnt && !m0.we) begin
      rdata0_d  = mem_rdata;
      rvalid0_d = 1'b1;
    end
    if (m1.gnt && !m1.we) begin
      rdata1_d  = mem_rdata;
      rvalid1_d = 1'b1;
    end
  end

  assign m0.rdata  = rdata0_q;
  assign m0.rvalid = rvalid0_q;
  assign m1.rdata  = rdata1_q;
  assign m1.rvalid = rvalid1_q;

`ifdef DMEM_ARB_LOCK_EN
  assign sel_lock = owner ? m1.lock : m0.lock;
`endif

  // An owner with its request dropped behaves exactly like IDLE.
  always_comb begin
    state_d = rr_state;
    last_d  = last_q;
`ifdef DMEM_ARB_LOCK_EN
    lock_cnt_d = '0;
`endif
    if (beat) begin
      last_d  = owner;
      state_d = other_req ? own_state(~owner) : own_state(owner);
`ifdef DMEM_ARB_LOCK_EN
      if (sel_lock) begin
        if (lock_cnt_q < LOCK_LAST) begin
          state_d    = own_state(owner);
          lock_cnt_d = lock_cnt_q + 1'b1;
        end else if (!other_req) begin
          lock_cnt_d = LOCK_SAT;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= P_DMA;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) m0_if ();
  dmem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) m1_if ();

  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    bit          r0, w0, l0;
    logic [5:0]  a0;
    logic [31:0] d0;
    bit          r1, w1;
    logic [5:0]  a1;
    logic [31:0] d1;
    bit          g0, g1;
  } vec_t;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  vec_t vt[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic vec_t v(bit r0, bit w0, bit l0, int a0, logic [31:0] d0,
                             bit r1, bit w1, int a1, logic [31:0] d1, bit g0, bit g1);
    vec_t x;
    x.r0 = r0; x.w0 = w0; x.l0 = l0; x.a0 = 6'(a0); x.d0 = d0;
    x.r1 = r1; x.w1 = w1; x.a1 = 6'(a1); x.d1 = d1;
    x.g0 = g0; x.g1 = g1;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(vec_t x);
    m0_if.req = x.r0; m0_if.we = x.w0; m0_if.addr = x.a0; m0_if.wdata = x.d0;
    m1_if.req = x.r1; m1_if.we = x.w1; m1_if.addr = x.a1; m1_if.wdata = x.d1;
`ifdef DMEM_ARB_LOCK_EN
    m0_if.lock = x.l0;
    m1_if.lock = 1'b0;
`endif
  endtask

  task automatic run_vec(vec_t x, string tag);
    logic [1:0] exp_rv;
    logic       exp_we;
    sb_t        e;
    @(posedge clk);
    #1 drive(x);
    @(negedge clk);
    cyc++;
    exp_rv = 2'b00;
    while (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      exp_rv[e.port] = 1'b1;
      if (e.port) chk({tag, " m1_rdata"}, m1_if.rdata, e.data);
      else        chk({tag, " m0_rdata"}, m0_if.rdata, e.data);
    end
    chk({tag, " rvalid"}, {30'd0, m1_if.rvalid, m0_if.rvalid}, {30'd0, exp_rv});
    chk({tag, " gnt"}, {30'd0, m1_if.gnt, m0_if.gnt}, {30'd0, x.g1, x.g0});
    exp_we = x.g0 ? x.w0 : (x.g1 ? x.w1 : 1'b0);
    chk({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, exp_we});
    if (x.g0 || x.g1) begin
      chk({tag, " mem_addr"}, {26'd0, mem_addr}, {26'd0, x.g0 ? x.a0 : x.a1});
      if (exp_we) chk({tag, " mem_wdata"}, mem_wdata, x.g0 ? x.d0 : x.d1);
    end
    if (x.g0) begin
      if (x.w0) ref_mem[x.a0] = x.d0;
      else      sb.push_back('{port: 1'b0, data: ref_mem[x.a0], cyc: cyc + 1});
    end
    if (x.g1) begin
      if (x.w1) ref_mem[x.a1] = x.d1;
      else      sb.push_back('{port: 1'b1, data: ref_mem[x.a1], cyc: cyc + 1});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA500_0000 | (i * 32'h0001_0101) | 32'h1;
      ref_mem[i] = 32'hA500_0000 | (i * 32'h0001_0101) | 32'h1;
    end
    reset = 1'b1;
    drive(v(0,0,0,0,0, 0,0,0,0, 0,0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset gnt", {30'd0, m1_if.gnt, m0_if.gnt}, 32'd0);
    chk("reset rvalid", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
    chk("reset m0_rdata", m0_if.rdata, 32'd0);
    chk("reset m1_rdata", m1_if.rdata, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset mem_addr", {26'd0, mem_addr}, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);

    // write from port 0, read back from port 1
    vt.push_back(v(1,1,0,5,32'hDEADBEEF, 0,0,0,0, 0,0));
    vt.push_back(v(1,1,0,5,32'hDEADBEEF, 0,0,0,0, 1,0));
    vt.push_back(v(0,0,0,0,0,            0,0,0,0, 0,0));
    vt.push_back(v(0,0,0,0,0,            1,0,5,0, 0,0));
    vt.push_back(v(0,0,0,0,0,            1,0,5,0, 0,1));
    vt.push_back(v(0,0,0,0,0,            0,0,0,0, 0,0));
    // contention alternates 0,1,0,1
    vt.push_back(v(1,0,0,1,0, 1,0,2,0, 0,0));
    vt.push_back(v(1,0,0,1,0, 1,0,2,0, 1,0));
    vt.push_back(v(1,0,0,1,0, 1,0,2,0, 0,1));
    vt.push_back(v(1,0,0,1,0, 1,0,2,0, 1,0));
    vt.push_back(v(1,0,0,1,0, 1,0,2,0, 0,1));
    vt.push_back(v(0,0,0,0,0, 0,0,0,0, 0,0));
    // port 1 streams reads 0..3
    vt.push_back(v(0,0,0,0,0, 1,0,0,0, 0,0));
    for (int i = 0; i < 4; i++) vt.push_back(v(0,0,0,0,0, 1,0,i,0, 0,1));
    vt.push_back(v(0,0,0,0,0, 0,0,0,0, 0,0));
    // crossed writes then reads
    vt.push_back(v(1,1,0,10,32'h12345678, 1,1,11,32'hCAFEF00D, 0,0));
    vt.push_back(v(1,1,0,10,32'h12345678, 1,1,11,32'hCAFEF00D, 1,0));
    vt.push_back(v(1,0,0,11,0,            1,1,11,32'hCAFEF00D, 0,1));
    vt.push_back(v(1,0,0,11,0,            0,0,0,0,             1,0));
    vt.push_back(v(1,0,0,10,0,            0,0,0,0,             1,0));
    vt.push_back(v(0,0,0,0,0,             0,0,0,0,             0,0));
    // port 0 drops req while owning, port 1 pending
    vt.push_back(v(1,0,0,20,0, 0,0,0,0,  0,0));
    vt.push_back(v(1,0,0,20,0, 0,0,0,0,  1,0));
    vt.push_back(v(0,0,0,0,0,  1,0,21,0, 0,0));
    vt.push_back(v(0,0,0,0,0,  1,0,21,0, 0,1));
    vt.push_back(v(0,0,0,0,0,  0,0,0,0,  0,0));
    vt.push_back(v(0,0,0,0,0,  0,0,0,0,  0,0));

    foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

    // reset while port 1 owns with a write pending
    run_vec(v(1,0,0,0,0, 1,1,30,32'h55AA55AA, 0,0), "rst0");
    run_vec(v(1,0,0,0,0, 1,1,30,32'h55AA55AA, 1,0), "rst1");
    run_vec(v(0,0,0,0,0, 1,1,30,32'h55AA55AA, 0,1), "rst2");
    reset = 1'b1;
    #1;
    chk("rst m1_gnt", {31'd0, m1_if.gnt}, 32'd0);
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst rvalid", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
    chk("rst m0_rdata", m0_if.rdata, 32'd0);
    sb.delete();
    drive(v(1,0,0,2,0, 1,0,3,0, 0,0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_vec(v(1,0,0,2,0, 1,0,3,0, 1,0), "post0");
    run_vec(v(1,0,0,2,0, 1,0,3,0, 0,1), "post1");
    run_vec(v(0,0,0,0,0, 0,0,0,0, 0,0), "post2");

`ifdef DMEM_ARB_LOCK_EN
    run_vec(v(1,0,1,40,0, 1,0,50,0, 0,0), "lock_idle");
    for (int i = 0; i < 8; i++) run_vec(v(1,0,1,40+i,0, 1,0,50,0, 1,0), $sformatf("lock%0d", i));
    run_vec(v(1,0,1,48,0, 1,0,50,0, 0,1), "lock_xfer");
    run_vec(v(0,0,0,0,0,  0,0,0,0,  0,0), "lock_end");
`endif

    run_vec(v(0,0,0,0,0, 0,0,0,0, 0,0), "drain");
    chk("scoreboard empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
